// File: rtl/mem_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and
// data access, one outstanding transaction at a time, round-robin on ties.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] BUSY_I = 3'd1;
  localparam logic [2:0] BUSY_D = 3'd2;
  localparam logic [2:0] DONE_I = 3'd3;
  localparam logic [2:0] DONE_D = 3'd4;

  logic [2:0] state;
  logic       token_d;   // 1: data side wins the next tie
  logic       grant_d;

  assign grant_d = dm_req & (~if_req | token_d);
  assign stall   = (if_req & ~if_valid) | (dm_req & ~dm_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      token_d   <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            token_d   <= 1'b0;
            state     <= BUSY_D;
          end else if (if_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            token_d  <= 1'b1;
            state    <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
            state    <= DONE_I;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            if (!mem_we) dm_rdata <= mem_rdata;
            dm_valid <= 1'b1;
            state    <= DONE_D;
          end
        end
        DONE_I: begin
          if_valid <= 1'b0;
          state    <= IDLE;
        end
        DONE_D: begin
          dm_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each task drives one scenario cycle by
// cycle and compares against hand-derived values.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if ({mem_req, mem_we, if_valid, dm_valid, stall} !== 5'b0) begin bad++;
      $display("FAIL reset_ctrl got=%b exp=00000", {mem_req, mem_we, if_valid, dm_valid, stall}); end
    total++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'd0) begin bad++;
      $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, if_rdata, dm_rdata}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h10; mem_ready = 1'b1; mem_rdata = 32'h00500093;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL fetch_stall_c0 got=%b exp=1", stall); end
    step();
    total++; if ({mem_req, mem_we} !== 2'b10) begin bad++; $display("FAIL fetch_req_c1 got=%b exp=10", {mem_req, mem_we}); end
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL fetch_addr_c1 got=%h exp=10", mem_addr); end
    total++; if ({stall, if_valid} !== 2'b10) begin bad++; $display("FAIL fetch_stall_c1 got=%b exp=10", {stall, if_valid}); end
    step();
    total++; if ({if_valid, dm_valid, stall, mem_req} !== 4'b1000) begin bad++;
      $display("FAIL fetch_done_c2 got=%b exp=1000", {if_valid, dm_valid, stall, mem_req}); end
    total++; if (if_rdata !== 32'h00500093) begin bad++; $display("FAIL fetch_rdata got=%h exp=00500093", if_rdata); end
    if_req = 1'b0;
    step();
    total++; if ({if_valid, mem_req} !== 2'b00) begin bad++; $display("FAIL fetch_c3 got=%b exp=00", {if_valid, mem_req}); end
  endtask

  task automatic test_tie();
    rst = 1'b1; step(); rst = 1'b0; step();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    if_req = 1'b1; if_addr = 32'h14;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
    step();
    total++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h100}) begin bad++;
      $display("FAIL tie_first got=%b/%h exp=10/100", {mem_req, mem_we}, mem_addr); end
    step();
    total++; if ({dm_valid, if_valid} !== 2'b10) begin bad++; $display("FAIL tie_dvalid got=%b exp=10", {dm_valid, if_valid}); end
    total++; if (dm_rdata !== 32'hCAFE0001) begin bad++; $display("FAIL tie_drdata got=%h exp=cafe0001", dm_rdata); end
    dm_req = 1'b0;
    step();
    total++; if ({mem_req, dm_valid, if_valid} !== 3'b000) begin bad++; $display("FAIL tie_c3 got=%b exp=000", {mem_req, dm_valid, if_valid}); end
    step();
    total++; if ({mem_req, mem_addr} !== {1'b1, 32'h14}) begin bad++;
      $display("FAIL tie_second got=%b/%h exp=1/14", mem_req, mem_addr); end
    step();
    total++; if ({if_valid, dm_valid, if_rdata} !== {2'b10, 32'hCAFE0001}) begin bad++;
      $display("FAIL tie_ivalid got=%b/%h exp=10/cafe0001", {if_valid, dm_valid}, if_rdata); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_store();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
    mem_ready = 1'b0; mem_rdata = 32'h55555555;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 4) mem_ready = 1'b1;
      total++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h200, 32'hDEADBEEF}) begin bad++;
        $display("FAIL store_hold c%0d got=%b/%h/%h exp=11/200/deadbeef", c, {mem_req, mem_we}, mem_addr, mem_wdata); end
      total++; if (dm_valid !== 1'b0) begin bad++; $display("FAIL store_early_valid c%0d got=%b exp=0", c, dm_valid); end
    end
    step();
    total++; if ({dm_valid, mem_req} !== 2'b10) begin bad++; $display("FAIL store_done got=%b exp=10", {dm_valid, mem_req}); end
    total++; if (dm_rdata !== 32'hCAFE0001) begin bad++; $display("FAIL store_rdata got=%h exp=cafe0001", dm_rdata); end
    dm_req = 1'b0; dm_we = 1'b0;
    step();
    total++; if ({dm_valid, mem_req} !== 2'b00) begin bad++; $display("FAIL store_after got=%b exp=00", {dm_valid, mem_req}); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr [4] = '{32'h40, 32'h30, 32'h40, 32'h30};
    int n_grant = 0;
    int n_valid = 0;
    logic prev_req = 1'b0;
    logic prev_valid = 1'b0;
    rst = 1'b1; step(); rst = 1'b0; step();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    if_req = 1'b1; if_addr = 32'h30;
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (mem_req && !prev_req) begin
        if (n_grant < 4) begin
          total++; if (mem_addr !== exp_addr[n_grant]) begin bad++;
            $display("FAIL rr_order grant%0d got=%h exp=%h", n_grant, mem_addr, exp_addr[n_grant]); end
        end
        n_grant++;
      end
      total++; if ((if_valid & dm_valid) || (prev_valid & (if_valid | dm_valid))) begin bad++;
        $display("FAIL rr_valid_pulse c%0d got=%b%b prev=%b exp=single", c, if_valid, dm_valid, prev_valid); end
      if (if_valid | dm_valid) n_valid++;
      prev_req = mem_req;
      prev_valid = if_valid | dm_valid;
    end
    total++; if (n_grant !== 4 || n_valid !== 4) begin bad++;
      $display("FAIL rr_count got=%0d/%0d exp=4/4", n_grant, n_valid); end
    dm_req = 1'b0; if_req = 1'b0;
    step();
  endtask

  task automatic test_addr_hold();
    if_req = 1'b1; if_addr = 32'h20; mem_ready = 1'b0; mem_rdata = 32'h11111111;
    step();
    total++; if ({mem_req, mem_addr} !== {1'b1, 32'h20}) begin bad++;
      $display("FAIL hold_grant got=%b/%h exp=1/20", mem_req, mem_addr); end
    if_addr = 32'h24;
    step();
    total++; if (mem_addr !== 32'h20) begin bad++; $display("FAIL hold_addr got=%h exp=20", mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'h22222222;
    step();
    total++; if ({if_valid, if_rdata} !== {1'b1, 32'h22222222}) begin bad++;
      $display("FAIL hold_rdata got=%b/%h exp=1/22222222", if_valid, if_rdata); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_busy();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; mem_ready = 1'b0; mem_rdata = 32'h0BADF00D;
    step();
    step();
    total++; if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin bad++;
      $display("FAIL rstb_busy got=%b/%h exp=1/300", mem_req, mem_addr); end
    rst = 1'b1;
    #1;
    total++; if ({mem_req, mem_addr} !== {1'b0, 32'h0}) begin bad++;
      $display("FAIL rstb_async got=%b/%h exp=0/0", mem_req, mem_addr); end
    mem_ready = 1'b1;
    step();
    total++; if ({dm_valid, if_valid} !== 2'b00) begin bad++; $display("FAIL rstb_novalid got=%b exp=00", {dm_valid, if_valid}); end
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h50;
    step();
    total++; if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin bad++;
      $display("FAIL rstb_token got=%b/%h exp=1/300", mem_req, mem_addr); end
    step();
    total++; if ({dm_valid, if_valid, dm_rdata} !== {2'b10, 32'h0BADF00D}) begin bad++;
      $display("FAIL rstb_done got=%b/%h exp=10/0badf00d", {dm_valid, if_valid}, dm_rdata); end
    dm_req = 1'b0; if_req = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_fetch();
    test_tie();
    test_store();
    test_round_robin();
    test_addr_hold();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
